// File: rtl/scf_pkg.sv
// Shared types, MIPS control-flow decode constants and pure classification helpers
// for the scf_stream_filter block.
package scf_pkg;

  typedef enum logic [2:0] {
    CLS_OTHER  = 3'd0,
    CLS_BR     = 3'd1,
    CLS_JMP    = 3'd2,
    CLS_JR     = 3'd3,
    CLS_REGIMM = 3'd4
  } scf_cls_e;

  localparam int unsigned NumClasses = 5;

  localparam logic [5:0] OpSpecial = 6'd0;
  localparam logic [5:0] OpRegimm  = 6'd1;
  localparam logic [5:0] OpJ       = 6'd2;
  localparam logic [5:0] OpJal     = 6'd3;
  localparam logic [5:0] OpBeq     = 6'd4;
  localparam logic [5:0] OpBne     = 6'd5;
  localparam logic [5:0] OpBlez    = 6'd6;
  localparam logic [5:0] OpBgtz    = 6'd7;

  localparam logic [5:0] FnJr   = 6'd8;
  localparam logic [5:0] FnJalr = 6'd9;

  localparam logic [4:0] RtBltz   = 5'd0;
  localparam logic [4:0] RtBgez   = 5'd1;
  localparam logic [4:0] RtBltzal = 5'd16;
  localparam logic [4:0] RtBgezal = 5'd17;

  function automatic scf_cls_e classify(input logic [31:0] instr);
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    scf_cls_e   cls;
    op    = instr[31:26];
    funct = instr[5:0];
    rt    = instr[20:16];
    if (op inside {OpBeq, OpBne, OpBlez, OpBgtz}) begin
      cls = CLS_BR;
    end else if (op inside {OpJ, OpJal}) begin
      cls = CLS_JMP;
    end else if (op == OpSpecial && (funct inside {FnJr, FnJalr})) begin
      cls = CLS_JR;
    end else if (op == OpRegimm && (rt inside {RtBltz, RtBgez, RtBltzal, RtBgezal})) begin
      cls = CLS_REGIMM;
    end else begin
      cls = CLS_OTHER;
    end
    return cls;
  endfunction

  // pc width is a top-level parameter, so callers pass the pc==0 test pre-reduced.
  function automatic logic is_null(input scf_cls_e cls, input logic pc_zero,
                                   input logic [31:0] instr);
    logic bad;
    case (cls)
      CLS_BR, CLS_JR, CLS_REGIMM: bad = pc_zero;
      CLS_JMP:                    bad = (instr[25:0] == 26'd0);
      default:                    bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/scf_fifo.sv
// Parametrised synchronous FIFO with occupancy output. A push while full is accepted
// only together with a pop; a push into an empty FIFO is visible the next cycle.
module scf_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     level_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned LvlW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             push_ok, pop_ok;

  always_comb begin
    empty_o  = (level_q == '0);
    full_o   = (level_q == LvlW'(Depth));
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Depth is a power of two, so pointer overflow is the wrap.
    if (push_ok) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AddrW'(1);
    if (push_ok && !pop_ok) begin
      level_d = level_q + LvlW'(1);
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/scf_stream_filter.sv
// Pipelined control-flow filter: classify register feeding an output FIFO.
// Define SCF_STREAM_STATS_EN to add per-class acceptance counters on class_cnt.
module scf_stream_filter
  import scf_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PC_W+32-1:0]        in_data,
  input  logic [4:0]                class_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_W+32-1:0]        out_data,
  output logic [2:0]                out_class,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [CNT_W-1:0]          drop_cnt
`ifdef SCF_STREAM_STATS_EN
  ,
  output logic [5*CNT_W-1:0]        class_cnt
`endif
);

  localparam int unsigned RecW = PC_W + 32;

  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  scf_cls_e        in_cls;
  logic            in_keep;
  logic            accept;

  logic            stg_valid_q, stg_valid_d;
  logic            stg_keep_q, stg_keep_d;
  scf_cls_e        stg_cls_q, stg_cls_d;
  logic [RecW-1:0] stg_data_q, stg_data_d;
  logic            stg_moves;

  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic [RecW+2:0] fifo_rdata;

  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    in_instr = in_data[31:0];
    in_pc    = in_data[RecW-1:32];
    in_cls   = classify(in_instr);
    in_keep  = class_en[in_cls] && !is_null(in_cls, in_pc == '0, in_instr);

    pop       = !fifo_empty && out_ready;
    push      = stg_valid_q && stg_keep_q && (!fifo_full || pop);
    // Dropped entries retire unconditionally; kept ones need a FIFO slot.
    stg_moves = stg_valid_q && (!stg_keep_q || !fifo_full || pop);
    in_ready  = !stg_valid_q || stg_moves;
    accept    = in_valid && in_ready;

    stg_valid_d = stg_valid_q;
    stg_keep_d  = stg_keep_q;
    stg_cls_d   = stg_cls_q;
    stg_data_d  = stg_data_q;
    if (accept) begin
      stg_valid_d = 1'b1;
      stg_keep_d  = in_keep;
      stg_cls_d   = in_cls;
      stg_data_d  = in_data;
    end else if (stg_moves) begin
      stg_valid_d = 1'b0;
    end

    drop_cnt_d = drop_cnt_q;
    if (stg_valid_q && !stg_keep_q && drop_cnt_q != '1) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid_q <= 1'b0;
      stg_keep_q  <= 1'b0;
      stg_cls_q   <= CLS_OTHER;
      stg_data_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_keep_q  <= stg_keep_d;
      stg_cls_q   <= stg_cls_d;
      stg_data_q  <= stg_data_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  scf_fifo #(
    .Width (RecW + 3),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i ({stg_cls_q, stg_data_q}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rdata[RecW-1:0];
  assign out_class = fifo_rdata[RecW+2:RecW];
  assign drop_cnt  = drop_cnt_q;

`ifdef SCF_STREAM_STATS_EN
  logic [NumClasses-1:0][CNT_W-1:0] class_cnt_q, class_cnt_d;

  always_comb begin
    class_cnt_d = class_cnt_q;
    if (accept && class_cnt_q[in_cls] != '1) begin
      class_cnt_d[in_cls] = class_cnt_q[in_cls] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      class_cnt_q <= '0;
    end else begin
      class_cnt_q <= class_cnt_d;
    end
  end

  assign class_cnt = class_cnt_q;
`endif

endmodule

// File: tb/tb_scf_stream_filter.sv
// Directed and randomized bench for scf_stream_filter against a record-level scoreboard.
// Covers the SCF_STREAM_STATS_EN counters when that macro is defined.
module tb_scf_stream_filter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [4:0]  class_en;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [2:0]  out_class;
  logic [2:0]  fifo_level;
  logic [15:0] drop_cnt;
`ifdef SCF_STREAM_STATS_EN
  logic [79:0] class_cnt;
`endif

  scf_stream_filter #(
    .PC_W  (32),
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .class_en   (class_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_class  (out_class),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
`ifdef SCF_STREAM_STATS_EN
    ,
    .class_cnt  (class_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          last_acc;
  logic [63:0] exp_data_q[$];
  int          exp_cls_q[$];
  int          exp_drops;
  int          exp_cc[5];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference classification written straight from the class table.
  function automatic int ref_class(input logic [31:0] ins);
    int op, funct, rt;
    op    = int'(ins >> 26);
    funct = int'(ins & 32'h3f);
    rt    = int'((ins >> 16) & 32'h1f);
    if (op >= 4 && op <= 7) return 1;
    if (op == 2 || op == 3) return 2;
    if (op == 0 && (funct == 8 || funct == 9)) return 3;
    if (op == 1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17)) return 4;
    return 0;
  endfunction

  function automatic bit ref_bad(input int c, input logic [31:0] pc, input logic [31:0] ins);
    if (c == 1 || c == 3 || c == 4) return pc == 32'd0;
    if (c == 2) return (ins & 32'h03ff_ffff) == 32'd0;
    return 1'b0;
  endfunction

  task automatic model_accept(input logic [63:0] d, input logic [4:0] en);
    int c;
    c = ref_class(d[31:0]);
    if (en[c] && !ref_bad(c, d[63:32], d[31:0])) begin
      exp_data_q.push_back(d);
      exp_cls_q.push_back(c);
    end else if (exp_drops < 65535) begin
      exp_drops++;
    end
    if (exp_cc[c] < 65535) exp_cc[c]++;
  endtask

  task automatic model_pop();
    chk("pop_expected", 64'(exp_data_q.size() != 0), 64'd1);
    if (exp_data_q.size() != 0) begin
      chk("pop_data", out_data, exp_data_q.pop_front());
      chk("pop_class", 64'(out_class), 64'(exp_cls_q.pop_front()));
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic cycle();
    #1;
    last_acc = in_valid && in_ready;
    if (last_acc) model_accept(in_data, class_en);
    if (out_valid && out_ready) model_pop();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input logic [63:0] d, input logic [4:0] en);
    in_valid = 1'b1;
    in_data  = d;
    class_en = en;
    last_acc = 1'b0;
    for (int g = 0; g < 30 && !last_acc; g++) cycle();
    chk("send_accepted", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int g = 0; g < 40 && (exp_data_q.size() != 0 || out_valid); g++) cycle();
    idle(2);
    chk("drain_queue_empty", 64'(exp_data_q.size()), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
  endtask

`ifdef SCF_STREAM_STATS_EN
  task automatic chk_stats(input string tag);
    for (int c = 0; c < 5; c++) chk(tag, 64'(class_cnt[c*16 +: 16]), 64'(exp_cc[c]));
  endtask
`endif

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: r[31:26] = 6'(4 + $urandom_range(0, 3));
      1: begin
        r[31:26] = 6'(2 + $urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) r[25:0] = 26'd0;
      end
      2: begin
        r[31:26] = 6'd0;
        r[5:0]   = 6'(8 + $urandom_range(0, 1));
      end
      3: begin
        r[31:26] = 6'd1;
        if ($urandom_range(0, 3) != 0) r[20:16] = 5'($urandom_range(0, 1) + 16 * $urandom_range(0, 1));
      end
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    class_en  = 5'h1f;
    out_ready = 1'b0;
    exp_drops = 0;
    foreach (exp_cc[c]) exp_cc[c] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_fifo_level", 64'(fifo_level), 64'd0);
    chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // beq: latency N+2 with unmodified data.
    in_valid = 1'b1;
    in_data  = {32'h0040_0000, 32'h1000_0003};
    cycle();
    chk("beq_accept", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
    #1 chk("beq_not_yet_n1", 64'(out_valid), 64'd0);
    cycle();
    #1;
    chk("beq_valid_n2", 64'(out_valid), 64'd1);
    chk("beq_class", 64'(out_class), 64'd1);
    chk("beq_data", out_data, {32'h0040_0000, 32'h1000_0003});
    drain();

    // j with zero target is dropped.
    send({32'h0040_0010, 32'h0800_0000}, 5'h1f);
    idle(3);
    chk("j_null_no_output", 64'(out_valid), 64'd0);
    chk("j_null_drop_cnt", 64'(drop_cnt), 64'd1);

    // jr $31: good pc forwarded, pc 0 dropped.
    send({32'h0040_0020, 32'h03e0_0008}, 5'h1f);
    send({32'h0000_0000, 32'h03e0_0008}, 5'h1f);
    drain();
    chk("jr_drop_cnt", 64'(drop_cnt), 64'd2);

    // bltz burst against a stalled sink.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send({32'h0000_1000 + 32'(i * 4), 32'h0400_0002}, 5'h1f);
    in_valid = 1'b1;
    in_data  = {32'h0000_1014, 32'h0400_0002};
    #1;
    chk("burst_in_ready_low", 64'(in_ready), 64'd0);
    chk("burst_fifo_full", 64'(fifo_level), 64'd4);
    out_ready = 1'b1;
    for (int i = 5; i < 8; i++) send({32'h0000_1000 + 32'(i * 4), 32'h0400_0002}, 5'h1f);
    drain();

    // add gated by class_en bit 0.
    send({32'h0040_0030, 32'h0085_1020}, 5'h1e);
    send({32'h0040_0034, 32'h0085_1020}, 5'h1f);
    drain();
    chk("add_drop_cnt", 64'(drop_cnt), 64'd3);

    // Randomized traffic with random backpressure and enables.
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = {($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom), rand_instr()};
      end
      class_en  = 5'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain();
`ifdef SCF_STREAM_STATS_EN
    chk_stats("stats_random");
`endif

    // Reset with three buffered records.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send({32'h0000_2000 + 32'(i * 4), 32'h1000_0003}, 5'h1f);
    idle(2);
    chk("pre_reset_level", 64'(fifo_level), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", 64'(out_valid), 64'd0);
    chk("mid_reset_level", 64'(fifo_level), 64'd0);
    chk("mid_reset_drop_cnt", 64'(drop_cnt), 64'd0);
    exp_data_q.delete();
    exp_cls_q.delete();
    exp_drops = 0;
    foreach (exp_cc[c]) exp_cc[c] = 0;
`ifdef SCF_STREAM_STATS_EN
    chk_stats("mid_reset_stats");
`endif
    @(negedge clk);
    rst_n = 1'b1;
    send({32'h0000_3000, 32'h0800_0040}, 5'h1f);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
